// File: rtl/ahb_arbiter_nm.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_nm
// Parametrised AHB bus arbiter for NUM_M masters. It supports fixed-priority
// or round-robin selection, locked transfers, parking on a default master
// and a burst hold limit. The grant is registered, and the address-phase
// owner (HMASTER/HMASTLOCK) follows the grant one accepted cycle later.
//
// Ports
//   i_hclk       bus clock
//   i_hresetn    asynchronous active-low reset
//   i_hbusreq    per-master bus request              [NUM_M]
//   i_hlock      per-master lock request             [NUM_M]
//   i_htrans     HTRANS of the current owner         [2]
//   i_hready     muxed slave ready
//   o_hgrant     one-hot grant (registered)          [NUM_M]
//   o_hmaster    address-phase owner index (reg.)    [max(1,MB)]
//   o_hmastlock  owner transfer is locked (reg.)
// ---------------------------------------------------------------------------
module ahb_arbiter_nm #(
  parameter int NUM_M     = 4,
  parameter int MODE      = 1,
  parameter int DEFAULT_M = 0,
  parameter int MAX_HOLD  = 16,
  localparam int MB       = $clog2(NUM_M),
  localparam int MBW      = (MB < 1) ? 1 : MB
) (
  input  logic             i_hclk,
  input  logic             i_hresetn,
  input  logic [NUM_M-1:0] i_hbusreq,
  input  logic [NUM_M-1:0] i_hlock,
  input  logic [1:0]       i_htrans,
  input  logic             i_hready,
  output logic [NUM_M-1:0] o_hgrant,
  output logic [MBW-1:0]   o_hmaster,
  output logic             o_hmastlock
);

  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0]    HOLD_LIM  = HW'(MAX_HOLD);
  localparam logic             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [MBW-1:0]   DEF_IDX   = MBW'(DEFAULT_M);
  localparam logic [NUM_M-1:0] ONE_M     = {{(NUM_M-1){1'b0}}, 1'b1};
  localparam logic [NUM_M-1:0] DEF_GRANT = ONE_M << DEFAULT_M;

  logic [NUM_M-1:0] r_grant;
  logic [MBW-1:0]   r_master;
  logic             r_mastlock;
  logic [MBW-1:0]   r_rr_ptr;
  logic [HW-1:0]    r_hold_cnt;

  logic [MBW-1:0]   w_g;
  logic [NUM_M-1:0] w_lock_req;
  logic             w_locked;
  logic             w_burst;
  logic             w_other_req;
  logic             w_hold_expired;
  logic             w_rearb;
  logic             w_any_req;
  logic [MBW-1:0]   w_fp_win;
  logic [MBW-1:0]   w_rr_win;
  logic [MBW-1:0]   w_winner;
  logic [NUM_M-1:0] w_win_grant;
  logic [NUM_M-1:0] w_grant_next;

  // Index of the (one-hot) granted master.
  always_comb begin
    w_g = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_grant[i]) w_g = w_g | MBW'(i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_lock_req
      assign w_lock_req[gi] = i_hlock[gi] & i_hbusreq[gi];
    end
  endgenerate

  assign w_locked    = w_lock_req[w_g];
  assign w_burst     = i_hbusreq[w_g] &
                       ((i_htrans == HTRANS_BUSY) | (i_htrans == HTRANS_SEQ));
  assign w_other_req = |(i_hbusreq & ~r_grant);
  // A burst only loses the bus once the limit is reached and someone else waits.
  assign w_hold_expired = HOLD_EN & (r_hold_cnt >= HOLD_LIM) & w_other_req;
  assign w_rearb     = i_hready & ~w_locked & ~(w_burst & ~w_hold_expired);
  assign w_any_req   = |i_hbusreq;

  // Fixed priority: lowest requesting index wins; park when idle.
  always_comb begin
    w_fp_win = DEF_IDX;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (i_hbusreq[i]) w_fp_win = MBW'(i);
    end
  end

  // Round robin: search starts just after the last winner, so the current
  // owner is examined last.
  always_comb begin
    logic         found;
    int           idx;
    logic [MBW-1:0] idx_b;
    w_rr_win = DEF_IDX;
    found    = 1'b0;
    idx      = 0;
    idx_b    = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_M) idx = idx - NUM_M;
      idx_b = MBW'(idx);
      if (!found && i_hbusreq[idx_b]) begin
        found    = 1'b1;
        w_rr_win = idx_b;
      end
    end
  end

  assign w_winner     = (MODE == 0) ? w_fp_win : w_rr_win;
  assign w_win_grant  = ONE_M << w_winner;
  assign w_grant_next = w_rearb ? w_win_grant : r_grant;

  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_grant    <= DEF_GRANT;
      r_master   <= DEF_IDX;
      r_mastlock <= 1'b0;
      r_rr_ptr   <= DEF_IDX;
      r_hold_cnt <= '0;
    end else if (i_hready) begin
      r_grant    <= w_grant_next;
      // Address-phase owner follows the grant one accepted cycle later.
      r_master   <= w_g;
      r_mastlock <= w_locked;
      // Parking does not move the round-robin pointer.
      if (w_rearb && w_any_req) r_rr_ptr <= w_winner;
      if (w_grant_next != r_grant) begin
        r_hold_cnt <= '0;
      end else if (i_htrans[1] && (r_hold_cnt != HOLD_LIM)) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end
    end
  end

  assign o_hgrant    = r_grant;
  assign o_hmaster   = r_master;
  assign o_hmastlock = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter_nm.sv
module tb_ahb_arbiter_nm;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NS   = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [3:0] busreq;
  logic [3:0] lock;
  logic [1:0] trans;
  logic       ready;

  logic [3:0] rr_grant, fp_grant;
  logic [1:0] rr_master, fp_master;
  logic       rr_mlock, fp_mlock;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lck;
    logic [1:0] trn;
    logic       rdy;
    logic [3:0] eg;
    logic [1:0] em;
    logic       el;
    int         eh;   // expected hold count, -1 = not checked
  } vec_t;

  vec_t rr_tab[18];
  vec_t fp_tab[14];

  // Round robin with a short hold limit.
  ahb_arbiter_nm #(.NUM_M(4), .MODE(1), .DEFAULT_M(0), .MAX_HOLD(4)) u_rr (
    .i_hclk(clk), .i_hresetn(rst_n), .i_hbusreq(busreq), .i_hlock(lock),
    .i_htrans(trans), .i_hready(ready),
    .o_hgrant(rr_grant), .o_hmaster(rr_master), .o_hmastlock(rr_mlock)
  );

  // Fixed priority, unlimited burst hold.
  ahb_arbiter_nm #(.NUM_M(4), .MODE(0), .DEFAULT_M(0), .MAX_HOLD(0)) u_fp (
    .i_hclk(clk), .i_hresetn(rst_n), .i_hbusreq(busreq), .i_hlock(lock),
    .i_htrans(trans), .i_hready(ready),
    .o_hgrant(fp_grant), .o_hmaster(fp_master), .o_hmastlock(fp_mlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int idx, input logic [6:0] act,
                     input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
               name, idx, act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0]);
    end else begin
      $display("ok   %s[%0d]: grant=%b master=%0d lock=%b", name, idx, act[6:3], act[2:1], act[0]);
    end
  endtask

  task automatic cmp_hold(input int idx, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL rr_hold[%0d]: got hold_cnt=%0d, want %0d", idx, act, exp);
    end else begin
      $display("ok   rr_hold[%0d]: hold_cnt=%0d", idx, act);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    busreq = '0; lock = '0; trans = IDLE; ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    busreq = v.req; lock = v.lck; trans = v.trn; ready = v.rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Round robin: rotation, parking, hold limit, HREADY stall.
    rr_tab[0]  = '{4'b1111, 4'b0000, NS,   1'b1, 4'b0010, 2'd0, 1'b0, 0};
    rr_tab[1]  = '{4'b1111, 4'b0000, NS,   1'b1, 4'b0100, 2'd1, 1'b0, 0};
    rr_tab[2]  = '{4'b1111, 4'b0000, NS,   1'b1, 4'b1000, 2'd2, 1'b0, 0};
    rr_tab[3]  = '{4'b1111, 4'b0000, NS,   1'b1, 4'b0001, 2'd3, 1'b0, 0};
    rr_tab[4]  = '{4'b1111, 4'b0000, NS,   1'b1, 4'b0010, 2'd0, 1'b0, 0};
    rr_tab[5]  = '{4'b0000, 4'b0000, IDLE, 1'b1, 4'b0001, 2'd1, 1'b0, 0};
    rr_tab[6]  = '{4'b0001, 4'b0000, IDLE, 1'b1, 4'b0001, 2'd0, 1'b0, 0};
    rr_tab[7]  = '{4'b0001, 4'b0000, NS,   1'b1, 4'b0001, 2'd0, 1'b0, 1};
    rr_tab[8]  = '{4'b0011, 4'b0000, SEQ,  1'b1, 4'b0001, 2'd0, 1'b0, 2};
    rr_tab[9]  = '{4'b0011, 4'b0000, SEQ,  1'b1, 4'b0001, 2'd0, 1'b0, 3};
    rr_tab[10] = '{4'b0011, 4'b0000, SEQ,  1'b1, 4'b0001, 2'd0, 1'b0, 4};
    rr_tab[11] = '{4'b0011, 4'b0000, SEQ,  1'b1, 4'b0010, 2'd0, 1'b0, 0};
    rr_tab[12] = '{4'b0010, 4'b0000, IDLE, 1'b1, 4'b0010, 2'd1, 1'b0, 0};
    rr_tab[13] = '{4'b0110, 4'b0000, IDLE, 1'b0, 4'b0010, 2'd1, 1'b0, 0};
    rr_tab[14] = '{4'b0110, 4'b0000, IDLE, 1'b0, 4'b0010, 2'd1, 1'b0, 0};
    rr_tab[15] = '{4'b0110, 4'b0000, IDLE, 1'b0, 4'b0010, 2'd1, 1'b0, 0};
    rr_tab[16] = '{4'b0110, 4'b0000, IDLE, 1'b1, 4'b0100, 2'd1, 1'b0, 0};
    rr_tab[17] = '{4'b0100, 4'b0000, IDLE, 1'b1, 4'b0100, 2'd2, 1'b0, 0};

    // Fixed priority: priority, park, lock, unlimited burst hold.
    fp_tab[0]  = '{4'b0101, 4'b0000, NS,   1'b1, 4'b0001, 2'd0, 1'b0, -1};
    fp_tab[1]  = '{4'b0100, 4'b0000, NS,   1'b1, 4'b0100, 2'd0, 1'b0, -1};
    fp_tab[2]  = '{4'b0000, 4'b0000, NS,   1'b1, 4'b0001, 2'd2, 1'b0, -1};
    fp_tab[3]  = '{4'b0000, 4'b0000, IDLE, 1'b1, 4'b0001, 2'd0, 1'b0, -1};
    fp_tab[4]  = '{4'b0010, 4'b0010, IDLE, 1'b1, 4'b0010, 2'd0, 1'b0, -1};
    fp_tab[5]  = '{4'b0011, 4'b0010, NS,   1'b1, 4'b0010, 2'd1, 1'b1, -1};
    fp_tab[6]  = '{4'b0011, 4'b0010, NS,   1'b1, 4'b0010, 2'd1, 1'b1, -1};
    fp_tab[7]  = '{4'b0011, 4'b0010, SEQ,  1'b1, 4'b0010, 2'd1, 1'b1, -1};
    fp_tab[8]  = '{4'b0011, 4'b0000, NS,   1'b1, 4'b0001, 2'd1, 1'b0, -1};
    fp_tab[9]  = '{4'b0011, 4'b0000, IDLE, 1'b1, 4'b0001, 2'd0, 1'b0, -1};
    fp_tab[10] = '{4'b0010, 4'b0000, IDLE, 1'b1, 4'b0010, 2'd0, 1'b0, -1};
    fp_tab[11] = '{4'b0011, 4'b0000, SEQ,  1'b1, 4'b0010, 2'd1, 1'b0, -1};
    fp_tab[12] = '{4'b0011, 4'b0000, SEQ,  1'b1, 4'b0010, 2'd1, 1'b0, -1};
    fp_tab[13] = '{4'b0011, 4'b0000, NS,   1'b1, 4'b0001, 2'd1, 1'b0, -1};

    rst_n = 1'b0;
    busreq = '0; lock = '0; trans = IDLE; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp("rr_reset", 0, {rr_grant, rr_master, rr_mlock}, {4'b0001, 2'd0, 1'b0});
    cmp("fp_reset", 0, {fp_grant, fp_master, fp_mlock}, {4'b0001, 2'd0, 1'b0});
    cmp_hold(-1, int'(u_rr.r_hold_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apply(rr_tab[i]);
      cmp("rr", i, {rr_grant, rr_master, rr_mlock},
          {rr_tab[i].eg, rr_tab[i].em, rr_tab[i].el});
      if (rr_tab[i].eh >= 0) cmp_hold(i, int'(u_rr.r_hold_cnt), rr_tab[i].eh);
    end

    do_reset();
    for (int i = 0; i < 14; i++) begin
      apply(fp_tab[i]);
      cmp("fp", i, {fp_grant, fp_master, fp_mlock},
          {fp_tab[i].eg, fp_tab[i].em, fp_tab[i].el});
    end

    // Asynchronous reset in the middle of a burst: M1 takes the grant first,
    // then reset lands between clock edges.
    @(negedge clk);
    busreq = 4'b0110; lock = 4'b0000; trans = SEQ; ready = 1'b1;
    @(posedge clk);
    #1;
    cmp("fp_pre_reset", 0, {fp_grant, fp_master, fp_mlock}, {4'b0010, 2'd0, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    cmp("fp_async_reset", 0, {fp_grant, fp_master, fp_mlock}, {4'b0001, 2'd0, 1'b0});
    cmp("rr_async_reset", 0, {rr_grant, rr_master, rr_mlock}, {4'b0001, 2'd0, 1'b0});
    cmp_hold(99, int'(u_rr.r_hold_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
